ad_uart_framer: RTL and testbench

//  Converts each AD conversion result (3-digit BCD + channel address from AD_Top) into
//  an ASCII text frame and streams it byte-by-byte to the UART transmitter in Uart_Top.

---
 rtl/ad_uart_framer_if.sv | 22 ++
 rtl/ad_uart_framer.sv | 137 +++++++++++++
 tb/tb_ad_uart_framer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ad_uart_framer_if.sv
// Handshake bundle between the AD sample source, the framer and the UART transmitter.
// The framer connects through the slave modport; the source/transmitter side uses master.
interface ad_uart_framer_if;
    logic [11:0] AD_BCDIn;
    logic [3:0]  AD_Address;
    logic        Sample_Valid;
    logic [7:0]  Tx_Data;
    logic        Tx_Valid;
    logic        Tx_Ready;
    logic        Frame_Busy;
    logic        Overrun;

    modport master (
        output AD_BCDIn, AD_Address, Sample_Valid, Tx_Ready,
        input  Tx_Data, Tx_Valid, Frame_Busy, Overrun
    );

    modport slave (
        input  AD_BCDIn, AD_Address, Sample_Valid, Tx_Ready,
        output Tx_Data, Tx_Valid, Frame_Busy, Overrun
    );
endinterface

// File: rtl/ad_uart_framer.sv
// Turns BCD AD samples into ASCII text frames streamed byte-by-byte to a UART transmitter.
// Define ADUART_CHECKSUM_EN to append a 2-char hex XOR checksum (10-byte frame).
//
// state | meaning
// IDLE  | waiting for a pending sample and an expired gap counter
// SEND  | presenting frame bytes to the transmitter, one per accepted handshake
module ad_uart_framer #(
    parameter int GAP_CYCLES = 2_500_000
) (
    input  logic Sys_CLK,
    input  logic Sys_RST,
    ad_uart_framer_if.slave bus
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
`ifdef ADUART_CHECKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 8;
`endif
    localparam logic [3:0] LAST = 4'(NB - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_nxt;
    logic          pending;
    logic [15:0]   pend_buf;
    logic [15:0]   frame;
    logic [3:0]    idx, idx_nxt;
    logic [GW-1:0] gap;
    logic          start;
    logic          tx_valid_nxt;
    logic [7:0]    tx_data_nxt;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] bcd_char(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    // f = {channel, d2, d1, d0}
    function automatic logic [7:0] frame_byte(input logic [15:0] f, input logic [3:0] i);
        logic [7:0] b;
`ifdef ADUART_CHECKSUM_EN
        logic [7:0] cs;
        cs = 8'h43 ^ hex_char(f[15:12]) ^ 8'h3A ^ bcd_char(f[11:8])
             ^ bcd_char(f[7:4]) ^ bcd_char(f[3:0]);
`endif
        case (i)
            4'd0:    b = 8'h43;
            4'd1:    b = hex_char(f[15:12]);
            4'd2:    b = 8'h3A;
            4'd3:    b = bcd_char(f[11:8]);
            4'd4:    b = bcd_char(f[7:4]);
            4'd5:    b = bcd_char(f[3:0]);
`ifdef ADUART_CHECKSUM_EN
            4'd6:    b = hex_char(cs[7:4]);
            4'd7:    b = hex_char(cs[3:0]);
            4'd8:    b = 8'h0D;
            4'd9:    b = 8'h0A;
`else
            4'd6:    b = 8'h0D;
            4'd7:    b = 8'h0A;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        tx_valid_nxt = bus.Tx_Valid;
        tx_data_nxt  = bus.Tx_Data;
        start        = 1'b0;
        case (state)
            IDLE: begin
                if (pending && (gap == '0)) begin
                    start        = 1'b1;
                    state_nxt    = SEND;
                    idx_nxt      = 4'd0;
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = frame_byte(pend_buf, 4'd0);
                end
            end
            SEND: begin
                if (bus.Tx_Valid && bus.Tx_Ready) begin
                    if (idx == LAST) begin
                        state_nxt    = IDLE;
                        tx_valid_nxt = 1'b0;
                    end else begin
                        idx_nxt     = idx + 4'd1;
                        tx_data_nxt = frame_byte(frame, idx + 4'd1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            state        <= IDLE;
            idx          <= 4'd0;
            bus.Tx_Valid <= 1'b0;
            bus.Tx_Data  <= 8'h00;
            bus.Overrun  <= 1'b0;
            pending      <= 1'b0;
            pend_buf     <= 16'h0000;
            frame        <= 16'h0000;
            gap          <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            bus.Tx_Valid <= tx_valid_nxt;
            bus.Tx_Data  <= tx_data_nxt;
            if (start)
                frame <= pend_buf;
            // A strobe in the accept cycle refills the buffer the frame just emptied.
            if (bus.Sample_Valid) begin
                pending  <= 1'b1;
                pend_buf <= {bus.AD_Address, bus.AD_BCDIn};
            end else if (start) begin
                pending <= 1'b0;
            end
            bus.Overrun <= bus.Sample_Valid && pending && !start;
            if (start)
                gap <= GAP_LOAD;
            else if (gap != '0)
                gap <= gap - GW'(1);
        end
    end

    assign bus.Frame_Busy = (state == SEND);
endmodule

// File: tb/tb_ad_uart_framer.sv
// Scoreboard bench for ad_uart_framer: stimulus pushes expected bytes, a monitor pops on each handshake.
module tb_ad_uart_framer;
    localparam int GAP = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ad_uart_framer_if bus();

    ad_uart_framer #(.GAP_CYCLES(GAP)) dut (
        .Sys_CLK (clk),
        .Sys_RST (rst),
        .bus     (bus)
    );

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];
    int starts[$];
    int xfer_count = 0;
    int ovr_count  = 0;
    int cycle      = 0;
    bit ready_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference frame built directly from the textual frame format.
    function automatic void push_frame(input logic [3:0] ch, input logic [11:0] bcd);
        string hx = "0123456789ABCDEF";
        logic [7:0] b[$];
        logic [3:0] d;
        logic [7:0] x;
        b.push_back("C");
        b.push_back(hx[ch]);
        b.push_back(":");
        for (int k = 2; k >= 0; k--) begin
            d = bcd[k*4 +: 4];
            b.push_back((d < 4'd10) ? (8'h30 + 8'(d)) : "?");
        end
`ifdef ADUART_CHECKSUM_EN
        x = 8'h00;
        for (int k = 0; k < 6; k++) x = x ^ b[k];
        b.push_back(hx[x[7:4]]);
        b.push_back(hx[x[3:0]]);
`else
        x = 8'h00;
`endif
        b.push_back(8'h0D);
        b.push_back(8'h0A);
        foreach (b[k]) exp_q.push_back(b[k]);
    endfunction

    task automatic push_list(input logic [7:0] l[]);
        foreach (l[k]) exp_q.push_back(l[k]);
    endtask

    task automatic strobe(input logic [3:0] ch, input logic [11:0] bcd);
        @(posedge clk); #1;
        bus.AD_Address   = ch;
        bus.AD_BCDIn     = bcd;
        bus.Sample_Valid = 1'b1;
        @(posedge clk); #1;
        bus.Sample_Valid = 1'b0;
        bus.AD_Address   = 4'($urandom);
        bus.AD_BCDIn     = 12'($urandom);
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || bus.Tx_Valid) && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_in_time"}, 32'(n < max), 1);
        check({name, "_busy_low_after"}, 32'(bus.Frame_Busy), 0);
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cycle++;
        #1;
        bus.Tx_Ready = ready_rand ? ($urandom_range(99) < 70) : 1'b1;
    end

    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(bus.Tx_Valid), 1);
                check("stall_data_held", 32'(bus.Tx_Data), 32'(prev_data));
            end
            if (bus.Tx_Valid)
                check("busy_while_valid", 32'(bus.Frame_Busy), 1);
            if (bus.Tx_Valid && !prev_valid)
                starts.push_back(cycle);
            if (bus.Tx_Valid && bus.Tx_Ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte (cycle %0d)", bus.Tx_Data, cycle);
                end else begin
                    check("tx_byte", 32'(bus.Tx_Data), 32'(exp_q.pop_front()));
                end
                xfer_count++;
            end
            if (bus.Overrun) ovr_count++;
            prev_stall = bus.Tx_Valid && !bus.Tx_Ready;
            prev_data  = bus.Tx_Data;
            prev_valid = bus.Tx_Valid;
        end
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got timeout, expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        int o, s, n, base, v;
        logic [3:0]  ch;
        logic [11:0] bcd;
        logic [7:0] t1[];
        logic [7:0] t3[];
`ifdef ADUART_CHECKSUM_EN
        t1 = '{8'h43, 8'h32, 8'h3A, 8'h33, 8'h35, 8'h37, 8'h37, 8'h41, 8'h0D, 8'h0A};
        t3 = '{8'h43, 8'h42, 8'h3A, 8'h39, 8'h3F, 8'h30, 8'h30, 8'h44, 8'h0D, 8'h0A};
`else
        t1 = '{8'h43, 8'h32, 8'h3A, 8'h33, 8'h35, 8'h37, 8'h0D, 8'h0A};
        t3 = '{8'h43, 8'h42, 8'h3A, 8'h39, 8'h3F, 8'h30, 8'h0D, 8'h0A};
`endif
        bus.AD_BCDIn     = 12'h000;
        bus.AD_Address   = 4'h0;
        bus.Sample_Valid = 1'b0;
        bus.Tx_Ready     = 1'b1;

        rst = 1'b1;
        idle(3); #1;
        check("reset_tx_data", 32'(bus.Tx_Data), 0);
        check("reset_tx_valid", 32'(bus.Tx_Valid), 0);
        check("reset_busy", 32'(bus.Frame_Busy), 0);
        check("reset_overrun", 32'(bus.Overrun), 0);
        @(negedge clk) rst = 1'b0;

        // basic frame
        o = ovr_count;
        push_list(t1);
        strobe(4'h2, 12'h357);
        drain("t1", 60);
        check("t1_no_overrun", 32'(ovr_count - o), 0);
        idle(GAP + 2);

        // hex channel and invalid BCD digit
        push_list(t3);
        strobe(4'hB, 12'h9A0);
        drain("t3", 60);
        idle(GAP + 2);

        // random backpressure and random samples
        ready_rand = 1'b1;
        push_list(t1);
        strobe(4'h2, 12'h357);
        drain("t2", 200);
        idle(GAP + 2);
        for (int i = 0; i < 10; i++) begin
            ch  = 4'($urandom);
            bcd = 12'($urandom);
            push_frame(ch, bcd);
            strobe(ch, bcd);
            drain("rand", 200);
            idle(GAP + 2);
        end
        ready_rand = 1'b0;
        idle(2);

        // overwrite during a frame: S0 then S3 only, two overruns
        o = ovr_count;
        s = starts.size();
        push_frame(4'h1, 12'h123);
        strobe(4'h1, 12'h123);
        idle(1);
        strobe(4'h4, 12'h456);
        strobe(4'h7, 12'h789);
        strobe(4'hE, 12'h210);
        push_frame(4'hE, 12'h210);
        drain("t4", 120);
        check("t4_overrun_pulses", 32'(ovr_count - o), 2);
        check("t4_frame_count", 32'(starts.size() - s), 2);
        if (starts.size() >= s + 2)
            check("t4_gap_respected", 32'((starts[s+1] - starts[s]) >= GAP), 1);
        idle(GAP + 5);

        // strobe on the exact accept cycle
        o = ovr_count;
        push_frame(4'h3, 12'h111);
        push_frame(4'hC, 12'h999);
        @(posedge clk); #1;
        bus.AD_Address = 4'h3; bus.AD_BCDIn = 12'h111; bus.Sample_Valid = 1'b1;
        @(posedge clk); #1;
        bus.AD_Address = 4'hC; bus.AD_BCDIn = 12'h999; bus.Sample_Valid = 1'b1;
        @(posedge clk); #1;
        bus.Sample_Valid = 1'b0;
        drain("t5", 120);
        check("t5_no_overrun", 32'(ovr_count - o), 0);
        idle(GAP + 5);

        // reset mid-frame
        push_frame(4'h5, 12'h864);
        base = xfer_count;
        strobe(4'h5, 12'h864);
        n = 0;
        while (xfer_count < base + 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_three_bytes_seen", 32'(n < 50), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("t6_valid_drops", 32'(bus.Tx_Valid), 0);
        check("t6_busy_drops", 32'(bus.Frame_Busy), 0);
        exp_q.delete();
        idle(3);
        @(negedge clk) rst = 1'b0;
        v = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.Tx_Valid) v++;
        end
        check("t6_no_resume", 32'(v), 0);
        push_frame(4'h0, 12'h042);
        strobe(4'h0, 12'h042);
        drain("t6_restart", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
